// File: rtl/peripheral_dbg_pu_or1k_pkg.sv
// Shared constants for the OR1K debug-side SPR arbiter: FSM state codes,
// SPR bus widths and the default access timeout.
package peripheral_dbg_pu_or1k_pkg;

    localparam int SPR_AW = 32;
    localparam int SPR_DW = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_ACK  = 2'd2;

endpackage

// File: rtl/peripheral_dbg_pu_or1k_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant_i+1
// (wrapping) and returns the first active request as one-hot and index.
module peripheral_dbg_pu_or1k_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant_i) + i) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_dbg_pu_or1k_spr_arbiter.sv
// Shares the OR1K SPR master port between NUM_REQ debug requesters, one access
// at a time. Optional BUSY timeout: PERIPHERAL_DBG_PU_OR1K_SPR_TIMEOUT_EN.
module peripheral_dbg_pu_or1k_spr_arbiter
    import peripheral_dbg_pu_or1k_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     cpu_clk_i,
    input  logic                     cpu_rstn_i,
    input  logic [NUM_REQ-1:0]       req_stb_i,
    input  logic [NUM_REQ-1:0]       req_we_i,
    input  logic [NUM_REQ*32-1:0]    req_addr_i,
    input  logic [NUM_REQ*32-1:0]    req_data_i,
    output logic [31:0]              req_data_o,
    output logic [NUM_REQ-1:0]       req_ack_o,
    output logic [NUM_REQ-1:0]       req_err_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [31:0]              cpu_addr_o,
    output logic [31:0]              cpu_data_o,
    input  logic [31:0]              cpu_data_i,
    output logic                     cpu_stb_o,
    output logic                     cpu_we_o,
    input  logic                     cpu_ack_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [SPR_AW-1:0]   addr_q, addr_d;
    logic [SPR_DW-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [SPR_DW-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [SPR_AW-1:0]   sel_addr;
    logic [SPR_DW-1:0]   sel_data;
    logic                sel_we;
    logic [NUM_REQ-1:0]  owner_oh;

`ifdef PERIPHERAL_DBG_PU_OR1K_SPR_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    peripheral_dbg_pu_or1k_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i        (req_stb_i),
        .last_grant_i (last_q),
        .gnt_o        (arb_gnt),
        .idx_o        (arb_idx),
        .valid_o      (arb_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_we   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
                sel_addr = req_addr_i[k*SPR_AW +: SPR_AW];
                sel_data = req_data_i[k*SPR_DW +: SPR_DW];
                sel_we   = req_we_i[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
`ifdef PERIPHERAL_DBG_PU_OR1K_SPR_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_BUSY;
                    last_d  = arb_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_data;
                    we_d    = sel_we;
`ifdef PERIPHERAL_DBG_PU_OR1K_SPR_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_BUSY: begin
                // A slave ack in the timeout cycle still counts as a normal completion.
                if (cpu_ack_i) begin
                    state_d = ST_ACK;
                    rdata_d = cpu_data_i;
`ifdef PERIPHERAL_DBG_PU_OR1K_SPR_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ACK;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
        if (!cpu_rstn_i) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            rdata_q <= '0;
`ifdef PERIPHERAL_DBG_PU_OR1K_SPR_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
`ifdef PERIPHERAL_DBG_PU_OR1K_SPR_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Request latches are only observed through BUSY-gated outputs, so no reset.
    always_ff @(posedge cpu_clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
    end

    always_comb begin
        owner_oh   = NUM_REQ'(1) << last_q;
        grant_o    = (state_q != ST_IDLE) ? owner_oh : '0;
        req_ack_o  = (state_q == ST_ACK) ? owner_oh : '0;
        req_data_o = (state_q == ST_ACK) ? rdata_q : '0;
`ifdef PERIPHERAL_DBG_PU_OR1K_SPR_TIMEOUT_EN
        req_err_o  = (state_q == ST_ACK && err_q) ? owner_oh : '0;
`else
        req_err_o  = '0;
`endif
        cpu_stb_o  = (state_q == ST_BUSY);
        cpu_we_o   = (state_q == ST_BUSY) && we_q;
        cpu_addr_o = (state_q == ST_BUSY) ? addr_q : '0;
        cpu_data_o = (state_q == ST_BUSY) ? wdata_q : '0;
    end

endmodule

// File: tb/tb_peripheral_dbg_pu_or1k_spr_arbiter.sv
// Self-checking bench for the SPR arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_peripheral_dbg_pu_or1k_spr_arbiter;

    localparam int NREQ = 2;
    localparam int TOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_stb = '0;
    logic [NREQ-1:0]      req_we = '0;
    logic [NREQ*32-1:0]   req_addr = '0;
    logic [NREQ*32-1:0]   req_wdata = '0;
    logic [31:0]          req_rdata;
    logic [NREQ-1:0]      ack_w, err_w, grant_w;
    logic [31:0]          cpu_addr_w, cpu_wdata_w;
    logic [31:0]          cpu_rdata = '0;
    logic                 cpu_stb_w, cpu_we_w;
    logic                 cpu_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripheral_dbg_pu_or1k_spr_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .cpu_clk_i  (clk),
        .cpu_rstn_i (rst_n),
        .req_stb_i  (req_stb),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_data_i (req_wdata),
        .req_data_o (req_rdata),
        .req_ack_o  (ack_w),
        .req_err_o  (err_w),
        .grant_o    (grant_w),
        .cpu_addr_o (cpu_addr_w),
        .cpu_data_o (cpu_wdata_w),
        .cpu_data_i (cpu_rdata),
        .cpu_stb_o  (cpu_stb_w),
        .cpu_we_o   (cpu_we_w),
        .cpu_ack_i  (cpu_ack)
    );

    // Round-robin rule: first active requester after the previous owner.
    function automatic int rr_pick(input logic [NREQ-1:0] act, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (act[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int k);
        logic [NREQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic idle_inputs();
        req_stb   = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        cpu_ack   = 1'b0;
        cpu_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        req_stb = '1;
        #1;
        checks++;
        if ({grant_w, ack_w, err_w, cpu_stb_w, cpu_we_w} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0", {grant_w, ack_w, err_w, cpu_stb_w, cpu_we_w});
        end
        checks++;
        if ({cpu_addr_w, cpu_wdata_w, req_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {cpu_addr_w, cpu_wdata_w, req_rdata});
        end
        @(negedge clk);
        checks++;
        if (grant_w !== '0 || cpu_stb_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_held grant %b stb %b exp 0", grant_w, cpu_stb_w);
        end
        req_stb = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (grant_w !== '0) begin
            errors++;
            $display("FAIL idle_no_req grant %b exp 0", grant_w);
        end
    endtask

    task automatic test_alternate();
        logic [31:0]     a [NREQ];
        logic            w [NREQ];
        logic [NREQ-1:0] prev_g, owner;
        logic [31:0]     exp_d;
        int              ngr, nack;
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            a[k] = $urandom;
            w[k] = 1'($urandom_range(0, 1));
            req_addr[k*32 +: 32]  = a[k];
            req_wdata[k*32 +: 32] = $urandom;
            req_we[k] = w[k];
        end
        req_stb = '1;
        prev_g = '0; owner = '0; exp_d = '0; ngr = 0; nack = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            @(negedge clk);
            cpu_ack = 1'b0;
            if (grant_w !== '0 && prev_g === '0) begin
                checks++;
                if (grant_w !== onehot(ngr % 2) || cpu_addr_w !== a[ngr % 2] || cpu_we_w !== w[ngr % 2]) begin
                    errors++;
                    $display("FAIL alt_grant%0d grant %b addr %h we %b exp grant %b addr %h we %b",
                             ngr, grant_w, cpu_addr_w, cpu_we_w, onehot(ngr % 2), a[ngr % 2], w[ngr % 2]);
                end
                owner = grant_w;
                ngr++;
            end
            if (ack_w !== '0) begin
                nack++;
                checks++;
                if (ack_w !== owner || req_rdata !== exp_d) begin
                    errors++;
                    $display("FAIL alt_ack ack %b data %h exp ack %b data %h", ack_w, req_rdata, owner, exp_d);
                end
                if (nack == 4) req_stb = '0;
            end
            if (cpu_stb_w) begin
                exp_d = $urandom;
                cpu_rdata = exp_d;
                cpu_ack = 1'b1;
            end
            prev_g = grant_w;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (nack != 4 || ngr != 4 || grant_w !== '0) begin
            errors++;
            $display("FAIL alt_count acks %0d grants %0d final grant %b exp 4 4 0", nack, ngr, grant_w);
        end
        idle_inputs();
    endtask

    task automatic test_single_read();
        int stb_cnt, ack_at;
        @(negedge clk);
        idle_inputs();
        req_addr[31:0] = 32'h0000_3000;
        req_stb = 2'b01;
        stb_cnt = 0; ack_at = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            cpu_ack = 1'b0;
            if (ack_w !== '0) begin
                if (ack_at < 0) ack_at = c;
                checks++;
                if (ack_w !== 2'b01 || req_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL rd_ack ack %b data %h exp 01 deadbeef", ack_w, req_rdata);
                end
                req_stb = '0;
            end
            if (cpu_stb_w) begin
                stb_cnt++;
                checks++;
                if (cpu_addr_w !== 32'h0000_3000 || cpu_we_w !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_bus addr %h we %b exp 00003000 0", cpu_addr_w, cpu_we_w);
                end
                cpu_ack = 1'b1;
                cpu_rdata = 32'hDEAD_BEEF;
            end
        end
        checks++;
        if (stb_cnt != 1 || ack_at != 2 || grant_w !== '0) begin
            errors++;
            $display("FAIL rd_timing stb_cycles %0d ack_cycle %0d grant %b exp 1 2 0", stb_cnt, ack_at, grant_w);
        end
        idle_inputs();
    endtask

    task automatic test_write_wait();
        int stb_cnt, nack;
        @(negedge clk);
        idle_inputs();
        req_addr[63:32]  = 32'h0000_2010;
        req_wdata[63:32] = 32'h1234_5678;
        req_we  = 2'b10;
        req_stb = 2'b10;
        stb_cnt = 0; nack = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cpu_ack = 1'b0;
            if (ack_w !== '0) begin
                nack++;
                checks++;
                if (ack_w !== 2'b10 || err_w !== 2'b00) begin
                    errors++;
                    $display("FAIL wr_ack ack %b err %b exp 10 00", ack_w, err_w);
                end
                req_stb = '0;
            end
            if (cpu_stb_w) begin
                stb_cnt++;
                checks++;
                if (cpu_addr_w !== 32'h0000_2010 || cpu_wdata_w !== 32'h1234_5678 || cpu_we_w !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_bus addr %h data %h we %b exp 00002010 12345678 1", cpu_addr_w, cpu_wdata_w, cpu_we_w);
                end
                if (stb_cnt == 6) begin
                    cpu_ack = 1'b1;
                    cpu_rdata = $urandom;
                end
            end
        end
        checks++;
        if (stb_cnt != 6 || nack != 1) begin
            errors++;
            $display("FAIL wr_count stb_cycles %0d acks %0d exp 6 1", stb_cnt, nack);
        end
        idle_inputs();
    endtask

    task automatic test_drop();
        int stb_cnt, nack;
        @(negedge clk);
        idle_inputs();
        req_addr[31:0] = $urandom;
        req_stb = 2'b01;
        stb_cnt = 0; nack = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            cpu_ack = 1'b0;
            if (grant_w[0] && req_stb[0]) req_stb = '0;
            if (ack_w !== '0) begin
                nack++;
                checks++;
                if (ack_w !== 2'b01) begin
                    errors++;
                    $display("FAIL drop_ack ack %b exp 01", ack_w);
                end
            end
            if (cpu_stb_w) begin
                stb_cnt++;
                if (stb_cnt == 3) cpu_ack = 1'b1;
            end
        end
        checks++;
        if (nack != 1 || stb_cnt != 3 || grant_w !== '0) begin
            errors++;
            $display("FAIL drop_count acks %0d stb_cycles %0d grant %b exp 1 3 0", nack, stb_cnt, grant_w);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
`ifdef PERIPHERAL_DBG_PU_OR1K_SPR_TIMEOUT_EN
        logic [31:0] d;
        int stb_cnt, nack;
        for (int run = 0; run < 2; run++) begin
            @(negedge clk);
            idle_inputs();
            req_addr[31:0] = $urandom;
            req_stb = 2'b01;
            d = $urandom | 32'h1;
            stb_cnt = 0; nack = 0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                cpu_ack = 1'b0;
                if (ack_w !== '0) begin
                    nack++;
                    checks++;
                    if (run == 0 && (ack_w !== 2'b01 || err_w !== 2'b01 || req_rdata !== 32'h0 || stb_cnt != TOUT)) begin
                        errors++;
                        $display("FAIL tout_err ack %b err %b data %h busy %0d exp 01 01 0 %0d", ack_w, err_w, req_rdata, stb_cnt, TOUT);
                    end
                    if (run == 1 && (ack_w !== 2'b01 || err_w !== 2'b00 || req_rdata !== d)) begin
                        errors++;
                        $display("FAIL tout_race ack %b err %b data %h exp 01 00 %h", ack_w, err_w, req_rdata, d);
                    end
                    req_stb = '0;
                end
                if (cpu_stb_w) begin
                    stb_cnt++;
                    if (run == 1 && stb_cnt == TOUT) begin
                        cpu_ack = 1'b1;
                        cpu_rdata = d;
                    end
                end
            end
            checks++;
            if (nack != 1) begin
                errors++;
                $display("FAIL tout_count run %0d acks %0d exp 1", run, nack);
            end
        end
`else
        int stb_cnt, nack;
        @(negedge clk);
        idle_inputs();
        req_stb = 2'b01;
        stb_cnt = 0; nack = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (cpu_stb_w) stb_cnt++;
            if (ack_w !== '0 || err_w !== '0) nack++;
        end
        checks++;
        if (stb_cnt != 60 || nack != 0) begin
            errors++;
            $display("FAIL no_tout busy %0d acks %0d exp 60 0", stb_cnt, nack);
        end
        cpu_ack = 1'b1;
        @(negedge clk);
        cpu_ack = 1'b0;
        req_stb = '0;
        checks++;
        if (ack_w !== 2'b01 || err_w !== 2'b00) begin
            errors++;
            $display("FAIL no_tout_ack ack %b err %b exp 01 00", ack_w, err_w);
        end
`endif
        repeat (2) @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] m_addr [NREQ];
        logic [31:0] m_data [NREQ];
        logic        m_we   [NREQ];
        int phase, owner, mlast, waits, w;
        logic [31:0] lat_addr, lat_data, exp_d;
        logic lat_we, acked;
        do_reset();
        phase = 0; owner = 0; mlast = NREQ - 1; waits = 0; acked = 1'b0;
        lat_addr = '0; lat_data = '0; lat_we = 1'b0; exp_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            m_addr[k] = '0; m_data[k] = '0; m_we[k] = 1'b0;
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            // Advance the model over the edge just taken, from what was driven before it.
            if (phase == 0) begin
                w = rr_pick(req_stb, mlast);
                if (w >= 0) begin
                    phase = 1; owner = w; mlast = w;
                    lat_addr = m_addr[w]; lat_data = m_data[w]; lat_we = m_we[w];
                    waits = $urandom_range(0, 3);
                end
            end else if (phase == 1) begin
                if (acked) phase = 2;
            end else begin
                phase = 0;
            end
            checks++;
            if (grant_w !== (phase != 0 ? onehot(owner) : '0) || cpu_stb_w !== (phase == 1)) begin
                errors++;
                $display("FAIL rnd_grant cyc %0d grant %b stb %b exp owner %0d phase %0d", c, grant_w, cpu_stb_w, owner, phase);
            end
            checks++;
            if (ack_w !== (phase == 2 ? onehot(owner) : '0) || err_w !== '0) begin
                errors++;
                $display("FAIL rnd_ack cyc %0d ack %b err %b exp owner %0d phase %0d", c, ack_w, err_w, owner, phase);
            end
            if (phase == 1) begin
                checks++;
                if (cpu_addr_w !== lat_addr || cpu_wdata_w !== lat_data || cpu_we_w !== lat_we) begin
                    errors++;
                    $display("FAIL rnd_bus cyc %0d addr %h data %h we %b exp %h %h %b", c, cpu_addr_w, cpu_wdata_w, cpu_we_w, lat_addr, lat_data, lat_we);
                end
            end
            if (phase == 2) begin
                checks++;
                if (req_rdata !== exp_d) begin
                    errors++;
                    $display("FAIL rnd_rdata cyc %0d data %h exp %h", c, req_rdata, exp_d);
                end
                req_stb[owner] = 1'b0;
            end
            for (int k = 0; k < NREQ; k++) begin
                if (!req_stb[k] && $urandom_range(0, 2) == 0) begin
                    m_addr[k] = $urandom; m_data[k] = $urandom; m_we[k] = 1'($urandom_range(0, 1));
                    req_addr[k*32 +: 32] = m_addr[k];
                    req_wdata[k*32 +: 32] = m_data[k];
                    req_we[k] = m_we[k];
                    req_stb[k] = 1'b1;
                end
            end
            acked = 1'b0;
            cpu_ack = 1'b0;
            cpu_rdata = $urandom;
            if (phase == 1) begin
                if (waits == 0) begin
                    exp_d = $urandom;
                    cpu_rdata = exp_d;
                    cpu_ack = 1'b1;
                    acked = 1'b1;
                end else begin
                    waits--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                cpu_ack = 1'b1;
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        req_addr[63:32] = $urandom;
        req_stb = 2'b10;
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_stb_w !== 1'b1 || grant_w !== 2'b10) begin
            errors++;
            $display("FAIL arst_pre stb %b grant %b exp 1 10", cpu_stb_w, grant_w);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant_w, ack_w, err_w, cpu_stb_w, cpu_we_w} !== '0 || {cpu_addr_w, cpu_wdata_w, req_rdata} !== '0) begin
            errors++;
            $display("FAIL arst_mid ctrl %b data %h exp 0",
                     {grant_w, ack_w, err_w, cpu_stb_w, cpu_we_w}, {cpu_addr_w, cpu_wdata_w, req_rdata});
        end
        @(negedge clk);
        req_stb = 2'b11;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_w !== 2'b01 || cpu_stb_w !== 1'b1) begin
            errors++;
            $display("FAIL arst_first grant %b stb %b exp 01 1", grant_w, cpu_stb_w);
        end
        req_stb = '0;
        cpu_ack = 1'b1;
        @(negedge clk);
        cpu_ack = 1'b0;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single_read();
        test_write_wait();
        test_drop();
        test_timeout();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
